// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle RV32M multiply/divide unit for the EX stage.
//            A small FSM (IDLE/MUL/DIV/FIX) sequences a registered multiply
//            with MUL_LAT cycles of latency and a radix-2 restoring divider
//            that runs WIDTH iterations plus one sign-fix cycle.
//            Divide-by-zero and signed overflow finish in one cycle.
// Ports    : clk            - clock, all state on rising edge
//            reset          - synchronous, active-high
//            start          - request, accepted only while busy==0
//            op[2:0]        - RV32M funct3 (MUL..REMU)
//            a, b           - rs1/rs2 operands, sampled on accepted start
//            flush          - abort in-flight op, drop same-cycle start
//            busy           - op in flight, stage must stall
//            done           - one-cycle pulse, result valid
//            result         - result, held until the next completion
// Config   : MULDIV_RESULT_CACHE_EN - when defined, remembers the last
//            normal divide so a matching DIV/DIVU/REM/REMU finishes in one
//            cycle. Invalidated by reset, flush and any multiply.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    c_one      = CW'(1);
    localparam logic [CW-1:0]    c_mul_last = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0]    c_div_last = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_int_min  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mul_res;
    logic [WIDTH-1:0] r_quo;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;

    // ---------------- multiply: product formed from the request operands
    // MUL takes the low half, so its signedness is irrelevant.
    logic               w_a_sgn, w_b_sgn;
    logic [WIDTH:0]     w_a_ext, w_b_ext;
    logic [2*WIDTH-1:0] w_ma, w_mb, w_prod;
    logic [WIDTH-1:0]   w_mul_sel;

    assign w_a_sgn   = a[WIDTH-1] & (op[1:0] != 2'b11);   // MULHU: a unsigned
    assign w_b_sgn   = b[WIDTH-1] & ~op[1];               // MULHSU/MULHU: b unsigned
    assign w_a_ext   = {w_a_sgn, a};
    assign w_b_ext   = {w_b_sgn, b};
    // Two's-complement product modulo 2^(2W) is exact for the bits we keep.
    assign w_ma      = {{(WIDTH-1){w_a_ext[WIDTH]}}, w_a_ext};
    assign w_mb      = {{(WIDTH-1){w_b_ext[WIDTH]}}, w_b_ext};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_sel = (op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    // ---------------- divide: request decode
    logic             w_div_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic             w_div_zero, w_div_ovf;
    logic [WIDTH-1:0] w_spec_res;
    logic             w_cache_hit;
    logic [WIDTH-1:0] w_cache_res;

    assign w_div_signed = ~op[0];
    assign w_a_neg      = w_div_signed & a[WIDTH-1];
    assign w_b_neg      = w_div_signed & b[WIDTH-1];
    assign w_a_mag      = w_a_neg ? -a : a;
    assign w_b_mag      = w_b_neg ? -b : b;
    assign w_div_zero   = (b == '0);
    assign w_div_ovf    = w_div_signed & (a == c_int_min) & (b == '1);
    // op[1] selects remainder. Zero: q=~0, r=a. Overflow: q=a, r=0.
    assign w_spec_res   = w_div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // ---------------- divide: one restoring step per cycle
    logic [WIDTH:0]   w_shift, w_diff;
    logic [WIDTH-1:0] w_q_fix, w_r_fix;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    // ---------------- sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            r_count   <= '0;
            r_mul_res <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Abort wins over everything, including a same-cycle start.
                r_state <= S_IDLE;
                busy    <= 1'b0;
                r_count <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (!op[2]) begin
                                if (MUL_LAT == 1) begin
                                    result <= w_mul_sel;
                                    done   <= 1'b1;
                                end else begin
                                    r_mul_res <= w_mul_sel;
                                    r_count   <= c_one;
                                    r_state   <= S_MUL;
                                    busy      <= 1'b1;
                                end
                            end else if (w_div_zero || w_div_ovf) begin
                                result <= w_spec_res;
                                done   <= 1'b1;
                            end else if (w_cache_hit) begin
                                result <= w_cache_res;
                                done   <= 1'b1;
                            end else begin
                                r_quo    <= w_a_mag;
                                r_rem    <= '0;
                                r_dvs    <= w_b_mag;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_is_rem <= op[1];
                                r_count  <= '0;
                                r_state  <= S_DIV;
                                busy     <= 1'b1;
                            end
                        end
                    end
                    S_MUL: begin
                        if (r_count == c_mul_last) begin
                            result  <= r_mul_res;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_count <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                    S_DIV: begin
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        if (r_count == c_div_last) begin
                            r_count <= '0;
                            r_state <= S_FIX;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                    S_FIX: begin
                        result  <= r_is_rem ? w_r_fix : w_q_fix;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MULDIV_RESULT_CACHE_EN
    // ---------------- last-divide result cache
    logic             r_cache_valid, r_cache_signed, r_pend_signed;
    logic [WIDTH-1:0] r_cache_a, r_cache_b, r_cache_quo, r_cache_rem;
    logic [WIDTH-1:0] r_pend_a, r_pend_b;
    logic             w_idle_start, w_div_load;

    assign w_idle_start = (r_state == S_IDLE) & start & ~flush;
    assign w_div_load   = w_idle_start & op[2] & ~w_div_zero & ~w_div_ovf & ~w_cache_hit;
    assign w_cache_hit  = r_cache_valid & (a == r_cache_a) & (b == r_cache_b)
                        & (w_div_signed == r_cache_signed);
    assign w_cache_res  = op[1] ? r_cache_rem : r_cache_quo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cache_valid  <= 1'b0;
            r_cache_signed <= 1'b0;
            r_cache_a      <= '0;
            r_cache_b      <= '0;
            r_cache_quo    <= '0;
            r_cache_rem    <= '0;
            r_pend_a       <= '0;
            r_pend_b       <= '0;
            r_pend_signed  <= 1'b0;
        end else if (flush || (w_idle_start && !op[2])) begin
            r_cache_valid <= 1'b0;
        end else begin
            // Operands of the divide in flight; committed when it completes.
            if (w_div_load) begin
                r_pend_a      <= a;
                r_pend_b      <= b;
                r_pend_signed <= w_div_signed;
            end
            if (r_state == S_FIX) begin
                r_cache_valid  <= 1'b1;
                r_cache_a      <= r_pend_a;
                r_cache_b      <= r_pend_b;
                r_cache_signed <= r_pend_signed;
                r_cache_quo    <= w_q_fix;
                r_cache_rem    <= w_r_fix;
            end
        end
    end
`else
    assign w_cache_hit = 1'b0;
    assign w_cache_res = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Directed self-checking bench for muldiv_sequencer (WIDTH=32,
//            MUL_LAT=2). Inputs change on the falling edge; outputs are
//            sampled on the falling edge. The accept cycle is cycle 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;
`ifdef MULDIV_RESULT_CACHE_EN
    localparam int HIT_CYC = 1;
`else
    localparam int HIT_CYC = 34;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              flush;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_sequencer #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Watch from cycle first_cyc until done (bounded); busy must be 1 on every
    // cycle before done and 0 in the done cycle. Returns at the done negedge.
    task automatic wait_done(input string tag, input int first_cyc,
                             input int exp_cyc, input logic [31:0] exp_res);
        int cyc;
        int busy_bad;
        bit seen;
        cyc      = first_cyc - 1;
        busy_bad = 0;
        seen     = 1'b0;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (!busy) busy_bad++;
        end
        check_eq({tag, " done seen"}, 32'(seen), 32'd1);
        check_eq({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, " busy low in done"}, 32'(busy), 32'd0);
        check_eq({tag, " busy gaps"}, 32'(busy_bad), 32'd0);
        check_eq({tag, " result"}, result, exp_res);
    endtask

    // Called at a negedge; that cycle becomes the accept cycle 0.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_cyc, input logic [31:0] exp_res);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag, 1, exp_cyc, exp_res);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset result", result, 32'd0);

        // Multiply
        run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 2, 32'hFFFFFFEB);
        @(negedge clk);
        check_eq("done one-cycle pulse", 32'(done), 32'd0);
        run_op("MULH min*min", 3'b001, 32'h80000000, 32'h80000000, 2, 32'h40000000);
        @(negedge clk);
        run_op("MULHU max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE);
        @(negedge clk);
        run_op("MULHSU -1*2", 3'b010, 32'hFFFFFFFF, 32'd2, 2, 32'hFFFFFFFF);
        @(negedge clk);

        // Normal divides (REM with same signed operands may hit the cache)
        run_op("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD);
        @(negedge clk);
        run_op("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, HIT_CYC, 32'hFFFFFFFF);
        @(negedge clk);
        run_op("DIVU 0xFFFFFFF9/2", 3'b101, 32'hFFFFFFF9, 32'd2, 34, 32'h7FFFFFFC);
        @(negedge clk);

        // Special cases
        run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
        @(negedge clk);
        run_op("REM 5/0", 3'b110, 32'd5, 32'd0, 1, 32'd5);
        @(negedge clk);
        run_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
        @(negedge clk);
        run_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);
        @(negedge clk);

        // Flush at cycle 10 of DIV 100/7
        run_op("MUL 7*3", 3'b000, 32'd7, 32'd3, 2, 32'd21);
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);          // cycles 1..9
        @(negedge clk);                     // cycle 10
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);                     // cycle 11
        check_eq("flush busy", 32'(busy), 32'd0);
        check_eq("flush done", 32'(done), 32'd0);
        check_eq("flush result held", result, 32'd21);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("flush no done", 32'(dones), 32'd0);

        // Reset at cycle 5 of DIV 100/7
        start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);          // cycles 1..4
        check_eq("div busy cycle 4", 32'(busy), 32'd1);
        @(negedge clk);                     // cycle 5
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("mid-op reset busy", 32'(busy), 32'd0);
        check_eq("mid-op reset done", 32'(done), 32'd0);
        check_eq("mid-op reset result", result, 32'd0);

        // Start while busy is ignored
        start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);          // cycles 1..3
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("DIV 100/7 start-while-busy", 4, 34, 32'd14);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("ignored start no done", 32'(dones), 32'd0);

        // Cache / back-to-back
        run_op("MULHU invalidate", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE);
        @(negedge clk);
        run_op("DIV 100/7", 3'b100, 32'd100, 32'd7, 34, 32'd14);
        run_op("REM 100/7 b2b", 3'b110, 32'd100, 32'd7, HIT_CYC, 32'd2);
        @(negedge clk);
        run_op("MULHU between", 3'b011, 32'd5, 32'd6, 2, 32'd0);
        @(negedge clk);
        run_op("REM 100/7 after mul", 3'b110, 32'd100, 32'd7, 34, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
